rpn_sequencer: RTL

- Upstream controller for the 8-bit `stack` block; evaluates a reverse-Polish token stream.
- Each token drives the stack's push/pop interface:
  - numbers are pushed;
  - operators pop two operands and push one result;
  - an EQ token pops the top and presents it as the result.
- It owns all stack traffic, so `stack` never sees push and pop in the same cycle.

---
 rtl/rpn_pkg.sv | 28 ++
 rtl/rpn_alu.sv | 33 +++
 rtl/rpn_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN sequencer: token kinds, opcodes and FSM states.
package rpn_pkg;

  localparam logic [1:0] KIND_NUM = 2'b00;
  localparam logic [1:0] KIND_OP  = 2'b01;
  localparam logic [1:0] KIND_EQ  = 2'b10;
  localparam logic [1:0] KIND_RSV = 2'b11;

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_AND = 3'b010;
  localparam logic [2:0] OPC_OR  = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_MUL = 3'b101;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP_B,
    ST_LAT_B,
    ST_POP_A,
    ST_LAT_A,
    ST_EXEC,
    ST_POP_R,
    ST_LAT_R
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN operator unit: r = a op b modulo 2^WIDTH, plus opcode legality.
// Define RPN_MUL_EN to make opcode 101 a multiply (low WIDTH bits); otherwise it is illegal.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             legal
);

  always_comb begin
    r     = '0;
    legal = 1'b1;
    case (op)
      OPC_ADD: r = a + b;
      OPC_SUB: r = a - b;
      OPC_AND: r = a & b;
      OPC_OR:  r = a | b;
      OPC_XOR: r = a ^ b;
`ifdef RPN_MUL_EN
      OPC_MUL: r = a * b;
`else
      OPC_MUL: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Reverse-Polish token evaluator driving an external push/pop stack.
// Optional multiply opcode is enabled by defining RPN_MUL_EN (handled inside rpn_alu).
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_kind,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_empty,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [2:0]       op_r;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] alu_r;
  logic             alu_legal;
  logic             accept;

  assign accept = tok_valid && tok_ready;
  // In IDLE the ALU only judges the incoming opcode; in EXEC it computes with the latched one.
  assign op_sel = (state == ST_IDLE) ? tok_data[2:0] : op_r;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (opa),
    .b     (opb),
    .op    (op_sel),
    .r     (alu_r),
    .legal (alu_legal)
  );

  always_comb begin
    state_nxt = state;
    tok_ready = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          case (tok_kind)
            KIND_NUM: state_nxt = ST_PUSH;
            KIND_OP:  state_nxt = alu_legal ? ST_POP_B : ST_IDLE;
            KIND_EQ:  state_nxt = ST_POP_R;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_PUSH: begin
        stk_push  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_POP_B: begin
        stk_pop   = !stk_empty;
        state_nxt = stk_empty ? ST_IDLE : ST_LAT_B;
      end
      ST_LAT_B: state_nxt = stk_empty ? ST_IDLE : ST_POP_A;
      ST_POP_A: begin
        stk_pop   = 1'b1;
        state_nxt = ST_LAT_A;
      end
      ST_LAT_A: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_PUSH;
      ST_POP_R: begin
        stk_pop   = !stk_empty;
        state_nxt = stk_empty ? ST_IDLE : ST_LAT_R;
      end
      ST_LAT_R: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control and every visible output register: cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      stk_data_in <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      err         <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state == ST_LAT_R);
      if (state == ST_IDLE && accept && tok_kind == KIND_NUM)
        stk_data_in <= tok_data;
      if (state == ST_EXEC)
        stk_data_in <= alu_r;
      if (state == ST_LAT_R)
        res_data <= stk_data_out;
      if ((state == ST_IDLE && accept && tok_kind == KIND_OP && !alu_legal) ||
          (state == ST_POP_B && stk_empty) ||
          (state == ST_LAT_B && stk_empty) ||
          (state == ST_POP_R && stk_empty))
        err <= 1'b1;
    end
  end

  // Operand datapath: no reset needed, always written before use.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept && tok_kind == KIND_OP)
      op_r <= tok_data[2:0];
    if (state == ST_LAT_B)
      opb <= stk_data_out;
    if (state == ST_LAT_A)
      opa <= stk_data_out;
  end

endmodule
